// File: rtl/ic_pkg.sv
// rtl/ic_pkg.sv - shared types and default constants for the interrupt requester
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } chan_state_t;

    localparam int NUM_SRC = 8;
    localparam int CNT_W   = 4;
    localparam int HOLDOFF = 2;

endpackage

// File: rtl/ic_irq_channel.sv
// rtl/ic_irq_channel.sv - one interrupt source channel: event counter plus IDLE/REQ/HOLD FSM
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   event_in      one-cycle event strobe
//   enable        channel enable; low clears the counter and parks the FSM in IDLE
//   ack_acc       ack already qualified by the top level (selected and in REQ)
//   overflow_clr  clear strobe for the sticky overflow flag
//   irq_req       high exactly while the FSM is in REQ
//   overflow      sticky counter-saturation flag
//   count_nz      counter is non-zero
module ic_irq_channel #(
    parameter int CNT_W   = ic_pkg::CNT_W,
    parameter int HOLDOFF = ic_pkg::HOLDOFF
) (
    input  logic clk,
    input  logic rst,
    input  logic event_in,
    input  logic enable,
    input  logic ack_acc,
    input  logic overflow_clr,
    output logic irq_req,
    output logic overflow,
    output logic count_nz
);

    ic_pkg::chan_state_t state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [2:0]          hold_cnt, hold_cnt_nxt;
    logic                ovf_nxt;
    logic                inc;
    logic                sat;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ic_pkg::IDLE;
            count    <= '0;
            hold_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            hold_cnt <= hold_cnt_nxt;
            overflow <= ovf_nxt;
        end
    end

    // Counter datapath: saturating, an event and an ack cancel out.
    always_comb begin
        inc       = event_in & enable;
        sat       = (count == {CNT_W{1'b1}});
        count_nxt = count;
        ovf_nxt   = overflow & ~overflow_clr;
        if (!enable) begin
            count_nxt = '0;
        end else if (inc && ack_acc) begin
            count_nxt = count;
        end else if (inc) begin
            if (sat) begin
                ovf_nxt = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end else if (ack_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    // Next-state logic; decisions look at count_nxt so an event landing on
    // the same edge as a transition is already accounted for.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (!enable) begin
            state_nxt    = ic_pkg::IDLE;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                ic_pkg::IDLE: begin
                    if (count_nxt != '0) state_nxt = ic_pkg::REQ;
                end
                ic_pkg::REQ: begin
                    if (ack_acc) begin
                        state_nxt    = ic_pkg::HOLD;
                        hold_cnt_nxt = 3'(HOLDOFF - 1);
                    end
                end
                ic_pkg::HOLD: begin
                    // Events only affect the counter, never the holdoff length.
                    if (hold_cnt == '0) begin
                        state_nxt = (count_nxt != '0) ? ic_pkg::REQ : ic_pkg::IDLE;
                    end else begin
                        hold_cnt_nxt = hold_cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt    = ic_pkg::IDLE;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded straight from registered state.
    always_comb begin
        irq_req  = (state == ic_pkg::REQ);
        count_nz = (count != '0);
    end

endmodule

// File: rtl/ic_irq_requester.sv
// rtl/ic_irq_requester.sv - per-source interrupt requester with ack decode and error reporting
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   event_in      per-source one-cycle event strobes
//   enable        per-channel enables
//   ack_in        acknowledge strobe, ack_id selects the channel
//   irq_req       per-channel level requests
//   overflow      per-channel sticky saturation flags, overflow_clr clears
//   ack_err       registered pulse for an ack that no channel accepted
//   pending_any   registered OR of all non-zero counters
module ic_irq_requester #(
    parameter int NUM_SRC = ic_pkg::NUM_SRC,
    parameter int CNT_W   = ic_pkg::CNT_W,
    parameter int HOLDOFF = ic_pkg::HOLDOFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] event_in,
    input  logic [NUM_SRC-1:0] enable,
    input  logic               ack_in,
    input  logic [2:0]         ack_id,
    output logic [NUM_SRC-1:0] irq_req,
    output logic [NUM_SRC-1:0] overflow,
    input  logic [NUM_SRC-1:0] overflow_clr,
    output logic               ack_err,
    output logic               pending_any
);

    logic [NUM_SRC-1:0] ack_acc;
    logic [NUM_SRC-1:0] count_nz;

    // Only the channel named by ack_id can accept, and only while in REQ;
    // an ack_id beyond NUM_SRC matches no channel and falls into ack_err.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
        assign ack_acc[i] = ack_in && (int'(ack_id) == i) && irq_req[i];

        ic_irq_channel #(
            .CNT_W   (CNT_W),
            .HOLDOFF (HOLDOFF)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .event_in     (event_in[i]),
            .enable       (enable[i]),
            .ack_acc      (ack_acc[i]),
            .overflow_clr (overflow_clr[i]),
            .irq_req      (irq_req[i]),
            .overflow     (overflow[i]),
            .count_nz     (count_nz[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_err     <= 1'b0;
            pending_any <= 1'b0;
        end else begin
            ack_err     <= ack_in && (ack_acc == '0);
            pending_any <= |count_nz;
        end
    end

endmodule
